// File: rtl/rambus_pkg.sv
// Shared widths and FSM state type for the OpenRAM rambus port-B arbiter.
package rambus_pkg;

    localparam int RAMBUS_ADR_W = 10;
    localparam int RAMBUS_DAT_W = 32;
    localparam int RAMBUS_SEL_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } rambus_arb_state_t;

endpackage

// File: rtl/rambus_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester after `last`,
// found by rotating a doubled request vector and priority-encoding it.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    input  logic [N-1:0]  skip,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_idx
);

    localparam int DW = $clog2(2 * N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [DW-1:0]  sh;
    logic [DW-1:0]  pos;
    logic           found;

    always_comb begin
        dbl      = {req & ~skip, req & ~skip};
        sh       = DW'(last) + DW'(1);
        rot      = '0;
        pos      = '0;
        found    = 1'b0;
        pick     = '0;
        pick_idx = '0;
        for (int j = 0; j < N; j++) begin
            rot[j] = dbl[sh + DW'(j)];
        end
        // rot[j] is master (last+1+j) mod N, so the lowest set bit wins
        for (int j = 0; j < N; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                pos   = sh + DW'(j);
                if (pos >= DW'(N)) begin
                    pos = pos - DW'(N);
                end
                pick_idx = IW'(pos);
            end
        end
        if (found) begin
            pick = N'(1) << pick_idx;
        end
    end

endmodule

// File: rtl/rambus_arbiter.sv
// Round-robin arbiter sharing OpenRAM port B between user projects, with a
// grant watchdog that revokes ownership from a master whose RAM never acks.
//
//   state | meaning
//   IDLE  | no owner, slave bus quiet, pick next requester after `last`
//   OWNED | grant_q owns port B until cyc/active drop or watchdog fires
module rambus_arbiter
    import rambus_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic                                 wb_clk_i,
    input  logic                                 wb_rst_i,
    input  logic [NUM_MASTERS-1:0]               active,
    input  logic [NUM_MASTERS-1:0]               m_cyc_i,
    input  logic [NUM_MASTERS-1:0]               m_stb_i,
    input  logic [NUM_MASTERS-1:0]               m_we_i,
    input  logic [RAMBUS_SEL_W*NUM_MASTERS-1:0]  m_sel_i,
    input  logic [RAMBUS_DAT_W*NUM_MASTERS-1:0]  m_dat_i,
    input  logic [RAMBUS_ADR_W*NUM_MASTERS-1:0]  m_adr_i,
    output logic [NUM_MASTERS-1:0]               m_ack_o,
    output logic [RAMBUS_DAT_W-1:0]              m_dat_o,
    output logic                                 rambus_wb_cyc_o,
    output logic                                 rambus_wb_stb_o,
    output logic                                 rambus_wb_we_o,
    output logic [RAMBUS_SEL_W-1:0]              rambus_wb_sel_o,
    output logic [RAMBUS_DAT_W-1:0]              rambus_wb_dat_o,
    output logic [RAMBUS_ADR_W-1:0]              rambus_wb_adr_o,
    input  logic                                 rambus_wb_ack_i,
    input  logic [RAMBUS_DAT_W-1:0]              rambus_wb_dat_i,
    output logic [NUM_MASTERS-1:0]               grant_o,
    output logic                                 timeout_o
);

    localparam int IW    = $clog2(NUM_MASTERS);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    rambus_arb_state_t      state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [NUM_MASTERS-1:0] skip_q, skip_d;
    logic [IW-1:0]          last_q, last_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   timeout_q, timeout_d;

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] pick;
    logic [IW-1:0]          pick_idx;
    logic                   g_cyc;
    logic                   g_act;
    logic                   wd_hit;

    assign req = m_cyc_i & active;

    rr_pick #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_pick (
        .req      (req),
        .last     (last_q),
        .skip     (skip_q),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    // grant_q is zero outside OWNED, so the mux alone keeps the slave bus quiet
    always_comb begin
        g_cyc           = 1'b0;
        g_act           = 1'b0;
        rambus_wb_cyc_o = 1'b0;
        rambus_wb_stb_o = 1'b0;
        rambus_wb_we_o  = 1'b0;
        rambus_wb_sel_o = '0;
        rambus_wb_dat_o = '0;
        rambus_wb_adr_o = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                g_cyc           = m_cyc_i[i];
                g_act           = active[i];
                rambus_wb_cyc_o = m_cyc_i[i] & active[i];
                rambus_wb_stb_o = m_stb_i[i] & active[i];
                rambus_wb_we_o  = m_we_i[i];
                rambus_wb_sel_o = m_sel_i[i*RAMBUS_SEL_W +: RAMBUS_SEL_W];
                rambus_wb_dat_o = m_dat_i[i*RAMBUS_DAT_W +: RAMBUS_DAT_W];
                rambus_wb_adr_o = m_adr_i[i*RAMBUS_ADR_W +: RAMBUS_ADR_W];
            end
        end
    end

    assign m_ack_o   = grant_q & {NUM_MASTERS{rambus_wb_ack_i}};
    assign m_dat_o   = rambus_wb_dat_i;
    assign grant_o   = grant_q;
    assign timeout_o = timeout_q;
    assign wd_hit    = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        skip_d    = skip_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                skip_d = '0;
                if (|pick) begin
                    grant_d = pick;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                    state_d = OWNED;
                end
            end
            OWNED: begin
                if (!g_cyc || !g_act) begin
                    grant_d = '0;
                    state_d = IDLE;
                end else if (rambus_wb_ack_i) begin
                    cnt_d = '0;
                end else if (wd_hit) begin
                    grant_d   = '0;
                    skip_d    = grant_q;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            skip_q    <= '0;
            last_q    <= IW'(NUM_MASTERS - 1);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            skip_q    <= skip_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: doc/rambus_arbiter.md
# rambus_arbiter

Round-robin arbiter that shares the single OpenRAM rambus Wishbone port (port B of the dual-port OpenRAM wrapper) between up to `NUM_MASTERS` user projects. It sits in `user_project_wrapper` between the per-project `rambus_wb_*` master outputs and the OpenRAM wrapper's port-B slave inputs. Only masters whose `active` bit is set may compete. A grant is held for a whole Wishbone cycle, and a watchdog revokes a grant from a stuck master.

## Interface
Parameters:
- `NUM_MASTERS`, default 4: number of requesting projects, 2..8.
- `TIMEOUT`, default 255: max cycles a grant may be held; 0 disables the watchdog.

Ports (packed vectors; master i occupies slice i):
- `wb_clk_i` input 1: single clock.
- `wb_rst_i` input 1: reset, synchronous, active-high.
- `active` input NUM_MASTERS: per-master enable, from LA `active` bits.
- `m_cyc_i` input NUM_MASTERS: master cycle.
- `m_stb_i` input NUM_MASTERS: master strobe.
- `m_we_i` input NUM_MASTERS: master write enable.
- `m_sel_i` input 4*NUM_MASTERS: byte selects.
- `m_dat_i` input 32*NUM_MASTERS: write data.
- `m_adr_i` input 10*NUM_MASTERS: word address.
- `m_ack_o` output NUM_MASTERS: ack, routed to the granted master only.
- `m_dat_o` output 32: read data, broadcast to all masters.
- `rambus_wb_cyc_o`, `rambus_wb_stb_o`, `rambus_wb_we_o` output 1 each: to RAM port B.
- `rambus_wb_sel_o` output 4: to RAM port B.
- `rambus_wb_dat_o` output 32: to RAM port B.
- `rambus_wb_adr_o` output 10: to RAM port B.
- `rambus_wb_ack_i` input 1: from RAM port B.
- `rambus_wb_dat_i` input 32: from RAM port B.
- `grant_o` output NUM_MASTERS: one-hot current grant, 0 when idle.
- `timeout_o` output 1: sticky flag, set on a watchdog revoke, cleared only by reset.

## Operation
- Request: `req[i] = m_cyc_i[i] & active[i]`.
- States: IDLE and OWNED.
- IDLE: if any `req`, pick the first requester searching from `last+1` upward with wrap-around. Register `grant` and `last` to that master, clear the watchdog counter, go to OWNED. If no request, stay in IDLE.
- OWNED, slave side: `rambus_wb_{cyc,stb,we,sel,dat,adr}_o` = granted master's signals, with `cyc`/`stb` gated by that master's `active`.
- OWNED, master side: `m_ack_o[g] = rambus_wb_ack_i`; all other `m_ack_o` bits are 0. `m_dat_o = rambus_wb_dat_i` at all times.
- Release: when the granted master drops `m_cyc_i`, or `active[g]` falls, next state is IDLE.
- Watchdog: the counter increments each OWNED cycle and clears on any ack. When the counter reaches `TIMEOUT` without an ack, next state is IDLE, `timeout_o` is set, and the stuck master is skipped for this arbitration round.
- A late ack from the RAM after release is dropped: no `m_ack_o` bit is asserted.
- Reset values: state IDLE, `grant_o`=0, `last`=NUM_MASTERS-1 (master 0 wins first), all `rambus_wb_*_o`=0, `m_ack_o`=0, `timeout_o`=0. A reset mid-transfer drops the cycle in the same edge.

## Timing
- Grant latency: a request first seen at edge n produces `grant_o` and slave `cyc`/`stb` after edge n+1.
- Slave-side muxing and ack return are combinational from registered `grant`. No added latency on ack or data.
- A release decided at edge k gives IDLE after k+1. The next grant is visible after k+2, so there is one dead cycle between owners, guaranteeing `rambus_wb_cyc_o` deasserts between masters.
- A master may issue back-to-back strobes inside one `cyc`. The grant persists; no re-arbitration happens until `cyc` falls.
- Simultaneous requests are resolved by round-robin order. A requester that loses waits at most NUM_MASTERS-1 grants.
- A request that appears in the same cycle as a release is considered at the next IDLE cycle.

## Structure
- Package `rambus_pkg`:
  - constants `RAMBUS_ADR_W`=10, `RAMBUS_DAT_W`=32, `RAMBUS_SEL_W`=4;
  - state enum `rambus_arb_state_t` {IDLE, OWNED}.
- Sub-module `rr_pick`: combinational round-robin picker.
  - inputs: `req`, `last` index, `skip` mask.
  - outputs: one-hot `pick` and `pick_idx`, computed by double-width rotate-and-priority.
- Top level contains the FSM, watchdog counter (width `$clog2(TIMEOUT+1)`), and output muxes.

## Test plan
- Single master: `active`=0001, master 0 writes 0xDEADBEEF to address 0x05, then reads it back. Expect `grant_o`=0001 one cycle after `cyc`, `m_dat_o`=0xDEADBEEF on the read ack, and `m_ack_o[3:1]` stays 0.
- Contention: masters 0..3 all assert `cyc` at reset release, each doing one write. Expect grant order 0,1,2,3 with exactly one idle cycle between grants and no overlapping `rambus_wb_cyc_o`.
- Fairness: master 1 re-requests immediately after each release while master 2 is also requesting. Expect grants to alternate 1,2,1,2.
- Inactive master: master 2 asserts `cyc` with `active[2]`=0. Expect `grant_o` never equals 0100 and no RAM access.
- Watchdog: `TIMEOUT`=8, master 0 holds `cyc`/`stb` while RAM `ack` is tied low. Expect release after 8 OWNED cycles, `timeout_o`=1, master 1 granted next, and `timeout_o` still 1 until `wb_rst_i`.
- Reset mid-cycle: assert `wb_rst_i` while master 3 is owned. Expect `grant_o`=0 and all `rambus_wb_*_o`=0 at the next edge; the first post-reset contention grants master 0.
